// File: rtl/hline_pkg.sv
// Shared types and widths for the burst arbiter slice.
package hline_pkg;

  localparam int MAX_LEN_DEF = 256;
  localparam int LEN_W       = 9;
  localparam int ADDR_W      = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

endpackage

// File: rtl/burst_arb_if.sv
// Requester and AXI-burst-master handshake bundle for burst_arb.
interface burst_arb_if import hline_pkg::*; #(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_write;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*LEN_W-1:0]  req_len;
  logic [NREQ-1:0]        req_grant;
  logic [NREQ-1:0]        req_done;
  logic                   req_err;
  logic                   m_go;
  logic                   m_rnw;
  logic [ADDR_W-1:0]      m_addr;
  logic [LEN_W-1:0]       m_len;
  logic                   m_done;

  // Arbiter side: takes requests and m_done, drives grants and the burst command.
  modport master (
    input  req_valid, req_write, req_addr, req_len, m_done,
    output req_grant, req_done, req_err, m_go, m_rnw, m_addr, m_len
  );

  // Environment side: requesters plus the AXI burst engine.
  modport slave (
    output req_valid, req_write, req_addr, req_len, m_done,
    input  req_grant, req_done, req_err, m_go, m_rnw, m_addr, m_len
  );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx
);

  logic        found;
  int unsigned cand;

  // Scan NREQ positions starting at ptr; the first requester seen wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned i = 0; i < unsigned'(NREQ); i++) begin
      cand = (32'(ptr) + i) % unsigned'(NREQ);
      if (!found && ((req >> cand) & NREQ'(1)) != '0) begin
        found = 1'b1;
        grant = NREQ'(1) << cand;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/burst_arb.sv
// Round-robin arbiter granting one requester at a time a single AXI burst,
// with length checking and a per-burst watchdog.
module burst_arb import hline_pkg::*; #(
  parameter int NREQ      = 2,
  parameter int MAX_LEN   = MAX_LEN_DEF,
  parameter int WD_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  burst_arb_if.master  bus,
  output logic         busy
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WD_W  = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
  localparam logic [LEN_W:0]  MAX_LEN_V = (LEN_W+1)'(MAX_LEN);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WD_CYCLES - 1);

  arb_state_e        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic [IDX_W-1:0]  own_idx, own_idx_nxt;
  logic [NREQ-1:0]   grant, grant_nxt;
  logic              err, err_nxt;
  logic              rnw, rnw_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [LEN_W-1:0]  len, len_nxt;
  logic [WD_W-1:0]   wd, wd_nxt, wd_inc;

  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;
  logic              len_ok;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // Route the candidate winner's command fields.
  always_comb begin
    sel_write = |(bus.req_write & pick_grant);
    sel_addr  = ADDR_W'(bus.req_addr >> (32'(pick_idx) * ADDR_W));
    sel_len   = LEN_W'(bus.req_len >> (32'(pick_idx) * LEN_W));
    len_ok    = (sel_len != '0) && ({1'b0, sel_len} <= MAX_LEN_V);
  end

  // Next-state and next-register values; every register holds by default.
  // The watchdog check looks at the incremented count so that expiry lands
  // DONE exactly WD_CYCLES cycles after the m_go pulse.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    own_idx_nxt = own_idx;
    grant_nxt   = grant;
    err_nxt     = err;
    rnw_nxt     = rnw;
    addr_nxt    = addr;
    len_nxt     = len;
    wd_nxt      = wd;
    wd_inc      = (wd == '1) ? wd : wd + 1'b1;
    case (state)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_nxt   = pick_grant;
          own_idx_nxt = pick_idx;
          rnw_nxt     = ~sel_write;
          addr_nxt    = sel_addr;
          len_nxt     = sel_len;
          if (len_ok) begin
            state_nxt = ISSUE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end
        end
      end
      ISSUE: begin
        wd_nxt    = '0;
        state_nxt = WAIT;
      end
      WAIT: begin
        wd_nxt = wd_inc;
        if (bus.m_done) begin
          err_nxt   = 1'b0;
          state_nxt = DONE;
        end else if (wd_inc == WD_LAST) begin
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        err_nxt   = 1'b0;
        grant_nxt = '0;
        ptr_nxt   = (32'(own_idx) == unsigned'(NREQ - 1)) ? '0 : own_idx + 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      own_idx <= '0;
      grant   <= '0;
      err     <= 1'b0;
      rnw     <= 1'b1;
      addr    <= '0;
      len     <= '0;
      wd      <= '0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      own_idx <= own_idx_nxt;
      grant   <= grant_nxt;
      err     <= err_nxt;
      rnw     <= rnw_nxt;
      addr    <= addr_nxt;
      len     <= len_nxt;
      wd      <= wd_nxt;
    end
  end

  assign bus.m_go      = (state == ISSUE);
  assign bus.req_done  = grant & {NREQ{state == DONE}};
  assign bus.req_grant = grant;
  assign bus.req_err   = err;
  assign bus.m_rnw     = rnw;
  assign bus.m_addr    = addr;
  assign bus.m_len     = len;
  assign busy          = (state != IDLE);

endmodule

// File: tb/tb_burst_arb.sv
// Directed scoreboard bench for burst_arb (NREQ=2, MAX_LEN=256, WD_CYCLES=16).
module tb_burst_arb;

  typedef struct {
    logic        rnw;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [1:0]  grant;
    logic        err;
  } exp_t;

  logic clk;
  logic reset;
  logic busy;

  burst_arb_if #(.NREQ(2)) bus ();

  burst_arb #(
    .NREQ      (2),
    .MAX_LEN   (256),
    .WD_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   go_cnt = 0;
  int   done_cnt = 0;
  int   go_cyc = 0;
  int   done_cyc = 0;
  exp_t exp_q[$];
  exp_t e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard monitor: m_go compared against the head entry, req_done pops it.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.m_go) begin
        go_cnt++;
        go_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("go_unexpected", 64'(bus.m_go), 64'd0);
        end else begin
          chk("go_grant", 64'(bus.req_grant), 64'(exp_q[0].grant));
          chk("go_rnw",   64'(bus.m_rnw),     64'(exp_q[0].rnw));
          chk("go_addr",  64'(bus.m_addr),    64'(exp_q[0].addr));
          chk("go_len",   64'(bus.m_len),     64'(exp_q[0].len));
        end
      end
      if (bus.req_done != 2'b00) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 64'(bus.req_done), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_vec",   64'(bus.req_done),  64'(e.grant));
          chk("done_grant", 64'(bus.req_grant), 64'(e.grant));
          chk("done_err",   64'(bus.req_err),   64'(e.err));
          chk("done_rnw",   64'(bus.m_rnw),     64'(e.rnw));
          chk("done_addr",  64'(bus.m_addr),    64'(e.addr));
          chk("done_len",   64'(bus.m_len),     64'(e.len));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [31:0] a, input logic [8:0] l);
    bus.req_write[i]       = wr;
    bus.req_addr[i*32 +: 32] = a;
    bus.req_len[i*9 +: 9]    = l;
  endtask

  task automatic push(input logic [1:0] g, input logic wr, input logic [31:0] a,
                      input logic [8:0] l, input logic er);
    exp_t x;
    x.rnw   = ~wr;
    x.addr  = a;
    x.len   = l;
    x.grant = g;
    x.err   = er;
    exp_q.push_back(x);
  endtask

  task automatic wait_go(input int g0, input string tag);
    for (int i = 0; i < 40 && go_cnt == g0; i++) step();
    chk({tag, "_go_seen"}, 64'(go_cnt - g0), 64'd1);
  endtask

  task automatic wait_done(input int d0, input string tag);
    for (int i = 0; i < 60 && done_cnt == d0; i++) step();
    chk({tag, "_done_seen"}, 64'(done_cnt - d0), 64'd1);
  endtask

  // AXI side answers k cycles after the m_go cycle.
  task automatic axi_reply(input int k);
    for (int i = 0; i < k; i++) step();
    bus.m_done = 1'b1;
    step();
    bus.m_done = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  64'(busy),          64'd0);
    chk({tag, "_grant"}, 64'(bus.req_grant), 64'd0);
    chk({tag, "_done"},  64'(bus.req_done),  64'd0);
    chk({tag, "_err"},   64'(bus.req_err),   64'd0);
    chk({tag, "_go"},    64'(bus.m_go),      64'd0);
    chk({tag, "_rnw"},   64'(bus.m_rnw),     64'd1);
    chk({tag, "_addr"},  64'(bus.m_addr),    64'd0);
    chk({tag, "_len"},   64'(bus.m_len),     64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int d0, g0, rc, prev_go;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.m_done    = 1'b0;
    step(); step(); step();
    chk_reset_vals("rst");
    reset = 1'b0;
    step();

    // m_done outside WAIT is ignored
    d0 = done_cnt;
    bus.m_done = 1'b1;
    step();
    bus.m_done = 1'b0;
    step();
    chk("idle_mdone_busy", 64'(busy), 64'd0);
    chk("idle_mdone_nodone", 64'(done_cnt - d0), 64'd0);

    // single write burst, len 256, reply after 10 cycles
    d0 = done_cnt; g0 = go_cnt;
    set_req(0, 1'b1, 32'h0000_1000, 9'd256);
    push(2'b01, 1'b1, 32'h0000_1000, 9'd256, 1'b0);
    bus.req_valid = 2'b01;
    rc = cyc;
    wait_go(g0, "b1");
    chk("b1_go_latency", 64'(go_cyc - rc), 64'd1);
    bus.req_valid = 2'b00;
    axi_reply(10);
    wait_done(d0, "b1");
    chk("b1_done_latency", 64'(done_cyc - go_cyc), 64'd11);
    step();
    chk("b1_done_pulse", 64'(bus.req_done), 64'd0);
    chk("b1_grant_clear", 64'(bus.req_grant), 64'd0);
    chk("b1_idle", 64'(busy), 64'd0);
    step(); step();
    chk("b1_go_once", 64'(go_cnt - g0), 64'd1);

    // both requesting from reset: alternating grants, back-to-back spacing
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    set_req(0, 1'b0, 32'h0000_2000, 9'd4);
    set_req(1, 1'b1, 32'h0000_3000, 9'd8);
    push(2'b01, 1'b0, 32'h0000_2000, 9'd4, 1'b0);
    push(2'b10, 1'b1, 32'h0000_3000, 9'd8, 1'b0);
    push(2'b01, 1'b0, 32'h0000_2000, 9'd4, 1'b0);
    push(2'b10, 1'b1, 32'h0000_3000, 9'd8, 1'b0);
    bus.req_valid = 2'b11;
    prev_go = 0;
    for (int b = 0; b < 4; b++) begin
      g0 = go_cnt;
      wait_go(g0, "rr");
      if (b > 0) chk("rr_go_spacing", 64'(go_cyc - prev_go), 64'd6);
      prev_go = go_cyc;
      d0 = done_cnt;
      axi_reply(3);
      wait_done(d0, "rr");
    end
    bus.req_valid = 2'b00;
    chk("rr_sb_empty", 64'(exp_q.size()), 64'd0);
    step();

    // illegal lengths: 0 then 300
    d0 = done_cnt; g0 = go_cnt;
    set_req(0, 1'b1, 32'h0000_4000, 9'd0);
    push(2'b01, 1'b1, 32'h0000_4000, 9'd0, 1'b1);
    bus.req_valid = 2'b01;
    rc = cyc;
    wait_done(d0, "len0");
    bus.req_valid = 2'b00;
    chk("len0_latency", 64'(done_cyc - rc), 64'd1);
    chk("len0_no_go", 64'(go_cnt - g0), 64'd0);
    step();
    chk("len0_err_clear", 64'(bus.req_err), 64'd0);
    d0 = done_cnt;
    set_req(1, 1'b0, 32'h0000_4400, 9'd300);
    push(2'b10, 1'b0, 32'h0000_4400, 9'd300, 1'b1);
    bus.req_valid = 2'b10;
    rc = cyc;
    wait_done(d0, "len300");
    bus.req_valid = 2'b00;
    chk("len300_latency", 64'(done_cyc - rc), 64'd1);
    chk("len300_no_go", 64'(go_cnt - g0), 64'd0);
    step();
    chk("len300_err_clear", 64'(bus.req_err), 64'd0);
    chk("len300_idle", 64'(busy), 64'd0);

    // watchdog timeout: no m_done
    d0 = done_cnt; g0 = go_cnt;
    set_req(0, 1'b0, 32'h0000_5000, 9'd16);
    push(2'b01, 1'b0, 32'h0000_5000, 9'd16, 1'b1);
    bus.req_valid = 2'b01;
    wait_go(g0, "wd");
    bus.req_valid = 2'b00;
    wait_done(d0, "wd");
    chk("wd_done_latency", 64'(done_cyc - go_cyc), 64'd16);
    step();

    // m_done on the watchdog-expiry cycle wins
    d0 = done_cnt; g0 = go_cnt;
    set_req(1, 1'b1, 32'h0000_6000, 9'd1);
    push(2'b10, 1'b1, 32'h0000_6000, 9'd1, 1'b0);
    bus.req_valid = 2'b10;
    wait_go(g0, "race");
    bus.req_valid = 2'b00;
    axi_reply(15);
    wait_done(d0, "race");
    chk("race_done_latency", 64'(done_cyc - go_cyc), 64'd16);
    step();

    // reset in WAIT abandons the burst
    d0 = done_cnt; g0 = go_cnt;
    set_req(0, 1'b1, 32'h0000_7000, 9'd32);
    push(2'b01, 1'b1, 32'h0000_7000, 9'd32, 1'b0);
    bus.req_valid = 2'b01;
    wait_go(g0, "rw");
    bus.req_valid = 2'b00;
    step(); step(); step();
    chk("rw_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals("rw");
    exp_q.delete();
    step(); step();
    chk("rw_no_done", 64'(done_cnt - d0), 64'd0);
    reset = 1'b0;
    step();
    g0 = go_cnt;
    set_req(0, 1'b0, 32'h0000_7100, 9'd2);
    push(2'b01, 1'b0, 32'h0000_7100, 9'd2, 1'b0);
    bus.req_valid = 2'b01;
    wait_go(g0, "rw2");
    bus.req_valid = 2'b00;
    axi_reply(2);
    wait_done(d0, "rw2");
    step();
    chk("end_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("end_idle", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
